buffer_fifo_ctrl: RTL and testbench
===================================

Name: buffer_fifo_ctrl

Overview:
- Pointer/handshake controller that turns the TCU register-array buffer into a valid/ready FIFO.
- Sits directly in front of the buffer:
  - Drives its wr_en, wr_ptr, rd_en and rd_ptr.
  - Tracks occupancy.
  - Supports synchronous flush, plus a drain sequence used before instruction-bundle switches.
- Data bits do not pass through this block. Buffer din is the producer data; buffer dout is the consumer data.

Parameters:
- ADDR_BW, 2, buffer address width; DEPTH = 2**ADDR_BW entries.
- AF_THRESH, 3, occupancy at or above which almost_full asserts (1..DEPTH).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of pointers/count/state; priority below rst.
- in_valid  in  1  producer has an entry.
- in_ready  out  1  controller accepts entry this cycle.
- out_valid  out  1  head entry present on buffer dout.
- out_ready  in  1  consumer takes head entry this cycle.
- drain_req  in  1  request: stop accepting, empty FIFO, report done.
- drain_done  out  1  one-cycle pulse when drain completes.
- wr_en  out  1  to buffer write enable.
- wr_ptr  out  ADDR_BW  to buffer write address.
- rd_en  out  1  to buffer read enable.
- rd_ptr  out  ADDR_BW  to buffer read address.
- count  out  ADDR_BW+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.

Behaviour:
- Reset (rst=1 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0, state=RUN.
  - Outputs in the following cycle: drain_done=0, in_ready=1, out_valid=0, empty=1, full=0, almost_full=0.
- States:
  - RUN: normal operation.
  - DRAIN: accept nothing, keep popping.
  - DONE: single cycle.
- Combinational outputs:
  - in_ready = (state==RUN) & !full & !flush.
  - push = in_valid & in_ready; wr_en = push.
  - out_valid = !empty & !flush; rd_en = !empty.
  - pop = out_valid & out_ready.
- Pointers and count:
  - wr_ptr increments on push; rd_ptr increments on pop. Both wrap modulo DEPTH (natural ADDR_BW overflow).
  - count += push - pop. Simultaneous push and pop leaves count unchanged; both pointers advance.
- Latency:
  - An entry pushed at cycle N is visible (out_valid=1, dout valid) at cycle N+1.
  - No same-cycle bypass: empty FIFO with in_valid gives out_valid=0 that cycle.
- Full:
  - in_ready=0 even if out_ready=1 the same cycle (no write-through-on-pop).
  - in_ready returns the cycle after a pop.
- Empty: out_valid=0 and rd_en=0; buffer dout is then 0 by buffer contract.
- FSM transitions:
  - RUN -> DRAIN on drain_req=1 (sampled at posedge). in_ready is already 0 in the next cycle.
  - DRAIN -> DONE when count==0 at posedge, or when count==1 and pop in that cycle.
  - DONE -> RUN unconditionally; drain_done=1 only while in DONE; in_ready=0 in DONE.
  - drain_req while in DRAIN or DONE is ignored.
  - drain_req in RUN with FIFO already empty gives DRAIN for one cycle, then DONE.
- flush=1 at posedge:
  - Pointers=0, count=0, state=RUN.
  - During the flush cycle in_ready=0 and out_valid=0, so no push/pop occurs.
  - flush during DRAIN aborts the drain with no drain_done pulse.
- rst mid-operation: same as reset; overrides flush and drain; in-flight entries are discarded.
- Invariant: count == (wr_ptr - rd_ptr) mod DEPTH, except count==DEPTH where wr_ptr==rd_ptr.

Test Plan:
- Fill then empty (ADDR_BW=2, AF_THRESH=3):
  - Stimulus: after reset, 4 pushes with out_ready=0, then out_ready=1 with in_valid=0.
  - Response: wr_ptr 0,1,2,3,0. almost_full rises when count=3; full=1 and in_ready=0 at count=4. Pops read rd_ptr 0,1,2,3; empty=1 after the 4th.
- Simultaneous push/pop:
  - Stimulus: count=2, in_valid=out_ready=1 for 5 cycles.
  - Response: count stays 2; wr_ptr and rd_ptr each advance 5 (wrap mod 4); data order preserved.
- Full with pop:
  - Stimulus: count=4, in_valid=1, out_ready=1 for one cycle.
  - Response: in_ready=0 that cycle; count=3 next cycle; in_ready=1 next cycle.
- Drain:
  - Stimulus: count=3, drain_req pulse, in_valid held 1, out_ready=1.
  - Response: no pushes after the request; 3 pops; DONE one cycle after the last pop with a single-cycle drain_done=1; then RUN and in_ready=1.
- Flush mid-drain:
  - Stimulus: count=2 in DRAIN, flush=1 for one cycle.
  - Response: count=0, wr_ptr=rd_ptr=0, state RUN, drain_done never asserts, out_valid=0 in the flush cycle.
- Reset mid-traffic:
  - Stimulus: rst=1 while count=3 and in_valid=out_ready=1.
  - Response: next cycle count=0, empty=1, in_ready=1, out_valid=0, pointers=0.

Source files
------------

// File: rtl/buffer_fifo_ctrl.sv
// Pointer, occupancy and drain controller that turns the TCU register-array
// buffer into a valid/ready FIFO; data never passes through this block.
module buffer_fifo_ctrl #(
    parameter int ADDR_BW   = 2,
    parameter int AF_THRESH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               drain_req,
    output logic               drain_done,
    output logic               wr_en,
    output logic [ADDR_BW-1:0] wr_ptr,
    output logic               rd_en,
    output logic [ADDR_BW-1:0] rd_ptr,
    output logic [ADDR_BW:0]   count,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic [1:0]         dbg_state_o
);

    localparam int DEPTH = 2 ** ADDR_BW;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_BW-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BW-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BW:0]   count_q, count_d;
    logic               push, pop;

    // Handshakes: a transfer happens only in a cycle where valid and ready are
    // both high at the posedge; ready never waits on valid, and during flush
    // both sides are forced idle so no transfer can occur.
    always_comb begin
        full        = (count_q == (ADDR_BW+1)'(DEPTH));
        empty       = (count_q == '0);
        almost_full = (count_q >= (ADDR_BW+1)'(AF_THRESH));
        in_ready    = (state_q == ST_RUN) && !full && !flush;
        push        = in_valid && in_ready;
        out_valid   = !empty && !flush;
        pop         = out_valid && out_ready;
        wr_en       = push;
        rd_en       = !empty;
        drain_done  = (state_q == ST_DONE);
        wr_ptr      = wr_ptr_q;
        rd_ptr      = rd_ptr_q;
        count       = count_q;
        dbg_state_o = state_q;
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            state_d  = ST_RUN;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ADDR_BW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + ADDR_BW'(1);
            if (push && !pop)      count_d = count_q + (ADDR_BW+1)'(1);
            else if (pop && !push) count_d = count_q - (ADDR_BW+1)'(1);
            case (state_q)
                ST_RUN:   if (drain_req) state_d = ST_DRAIN;
                // Done once the last entry leaves, including the popping cycle itself.
                ST_DRAIN: if (empty || (count_q == (ADDR_BW+1)'(1) && pop)) state_d = ST_DONE;
                ST_DONE:  state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_buffer_fifo_ctrl.sv
// Directed vector table plus hand-written sequences for buffer_fifo_ctrl
// (ADDR_BW=2, AF_THRESH=3), with a small buffer model for data ordering.
module tb_buffer_fifo_ctrl;

    typedef struct packed {
        logic       ir;
        logic       ov;
        logic       we;
        logic       re;
        logic [1:0] wp;
        logic [1:0] rp;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       dd;
    } outs_t;

    typedef struct packed {
        logic  iv;
        logic  ordy;
        logic  dr;
        logic  fl;
        outs_t exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       drain_req;
    logic       drain_done;
    logic       wr_en;
    logic [1:0] wr_ptr;
    logic       rd_en;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [1:0] dbg_state;
    outs_t      act;

    int n_vec;
    int n_fail;

    logic [7:0] mem [4];
    logic [7:0] exp_q [$];
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] exp_d;

    vec_t vecs [36];

    buffer_fifo_ctrl #(.ADDR_BW(2), .AF_THRESH(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .drain_req   (drain_req),
        .drain_done  (drain_done),
        .wr_en       (wr_en),
        .wr_ptr      (wr_ptr),
        .rd_en       (rd_en),
        .rd_ptr      (rd_ptr),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .dbg_state_o (dbg_state)
    );

    assign act = {in_ready, out_valid, wr_en, rd_en, wr_ptr, rd_ptr, count, full, empty, almost_full, drain_done};

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input int iv, input int ordy, input int dr, input int fl,
                                input int ir, input int ov, input int we, input int re,
                                input int wp, input int rp, input int cnt,
                                input int fu, input int em, input int af, input int dd);
        vec_t v;
        v.iv        = 1'(iv);
        v.ordy      = 1'(ordy);
        v.dr        = 1'(dr);
        v.fl        = 1'(fl);
        v.exp.ir    = 1'(ir);
        v.exp.ov    = 1'(ov);
        v.exp.we    = 1'(we);
        v.exp.re    = 1'(re);
        v.exp.wp    = 2'(wp);
        v.exp.rp    = 2'(rp);
        v.exp.cnt   = 3'(cnt);
        v.exp.full  = 1'(fu);
        v.exp.empty = 1'(em);
        v.exp.af    = 1'(af);
        v.exp.dd    = 1'(dd);
        return v;
    endfunction

    task automatic check_outs(input string name, input outs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got ir=%b ov=%b we=%b re=%b wp=%0d rp=%0d cnt=%0d full=%b empty=%b af=%b dd=%b, expected ir=%b ov=%b we=%b re=%b wp=%0d rp=%0d cnt=%0d full=%b empty=%b af=%b dd=%b",
                     name, act.ir, act.ov, act.we, act.re, act.wp, act.rp, act.cnt, act.full, act.empty, act.af, act.dd,
                     exp.ir, exp.ov, exp.we, exp.re, exp.wp, exp.rp, exp.cnt, exp.full, exp.empty, exp.af, exp.dd);
        end
    endtask

    // driver: inputs change on negedge, outputs sampled 1 time unit later
    task automatic drive(input logic iv, input logic ordy, input logic dr, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        drain_req = dr;
        flush     = fl;
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drain_req = 1'b0;
        din       = '0;

        //          iv or dr fl | ir ov we re wp rp cnt fu em af dd
        // fill then empty
        vecs[0]  = mk(1, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0,   1, 1, 1, 1, 1, 0, 1,  0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0,   1, 1, 1, 1, 2, 0, 2,  0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 0,   1, 1, 1, 1, 3, 0, 3,  0, 0, 1, 0);
        vecs[4]  = mk(0, 1, 0, 0,   0, 1, 0, 1, 0, 0, 4,  1, 0, 1, 0);
        vecs[5]  = mk(0, 1, 0, 0,   1, 1, 0, 1, 0, 1, 3,  0, 0, 1, 0);
        vecs[6]  = mk(0, 1, 0, 0,   1, 1, 0, 1, 0, 2, 2,  0, 0, 0, 0);
        vecs[7]  = mk(0, 1, 0, 0,   1, 1, 0, 1, 0, 3, 1,  0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
        // simultaneous push/pop at count 2
        vecs[9]  = mk(1, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0);
        vecs[10] = mk(1, 0, 0, 0,   1, 1, 1, 1, 1, 0, 1,  0, 0, 0, 0);
        vecs[11] = mk(1, 1, 0, 0,   1, 1, 1, 1, 2, 0, 2,  0, 0, 0, 0);
        vecs[12] = mk(1, 1, 0, 0,   1, 1, 1, 1, 3, 1, 2,  0, 0, 0, 0);
        vecs[13] = mk(1, 1, 0, 0,   1, 1, 1, 1, 0, 2, 2,  0, 0, 0, 0);
        vecs[14] = mk(1, 1, 0, 0,   1, 1, 1, 1, 1, 3, 2,  0, 0, 0, 0);
        vecs[15] = mk(1, 1, 0, 0,   1, 1, 1, 1, 2, 0, 2,  0, 0, 0, 0);
        // full with pop: no write-through, ready returns next cycle
        vecs[16] = mk(1, 0, 0, 0,   1, 1, 1, 1, 3, 1, 2,  0, 0, 0, 0);
        vecs[17] = mk(1, 0, 0, 0,   1, 1, 1, 1, 0, 1, 3,  0, 0, 1, 0);
        vecs[18] = mk(1, 1, 0, 0,   0, 1, 0, 1, 1, 1, 4,  1, 0, 1, 0);
        vecs[19] = mk(0, 0, 0, 0,   1, 1, 0, 1, 1, 2, 3,  0, 0, 1, 0);
        // drain from count 3 with producer still pushing
        vecs[20] = mk(0, 0, 1, 0,   1, 1, 0, 1, 1, 2, 3,  0, 0, 1, 0);
        vecs[21] = mk(1, 1, 0, 0,   0, 1, 0, 1, 1, 2, 3,  0, 0, 1, 0);
        vecs[22] = mk(1, 1, 0, 0,   0, 1, 0, 1, 1, 3, 2,  0, 0, 0, 0);
        vecs[23] = mk(1, 1, 0, 0,   0, 1, 0, 1, 1, 0, 1,  0, 0, 0, 0);
        vecs[24] = mk(1, 1, 0, 0,   0, 0, 0, 0, 1, 1, 0,  0, 1, 0, 1);
        vecs[25] = mk(1, 1, 0, 0,   1, 0, 1, 0, 1, 1, 0,  0, 1, 0, 0);
        // flush in the middle of a drain at count 2
        vecs[26] = mk(1, 0, 0, 0,   1, 1, 1, 1, 2, 1, 1,  0, 0, 0, 0);
        vecs[27] = mk(0, 0, 1, 0,   1, 1, 0, 1, 3, 1, 2,  0, 0, 0, 0);
        vecs[28] = mk(0, 0, 0, 0,   0, 1, 0, 1, 3, 1, 2,  0, 0, 0, 0);
        vecs[29] = mk(1, 1, 0, 1,   0, 0, 0, 1, 3, 1, 2,  0, 0, 0, 0);
        vecs[30] = mk(0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
        vecs[31] = mk(0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
        // drain on an already-empty FIFO; repeated requests ignored
        vecs[32] = mk(0, 0, 1, 0,   1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
        vecs[33] = mk(1, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
        vecs[34] = mk(1, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1);
        vecs[35] = mk(0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outs("reset_state", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0).exp);

        for (int i = 0; i < 36; i++) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].dr, vecs[i].fl);
            check_outs($sformatf("vec%0d", i), vecs[i].exp);
        end

        // data order through a model of the register-array buffer
        drive(0, 0, 0, 0);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            din       = 8'($urandom_range(0, 255));
            #1;
            dout = rd_en ? mem[rd_ptr] : 8'h00;
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_on_empty: got dout=%0h, expected no pop", dout);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (dout !== exp_d) begin
                        n_fail++;
                        $display("FAIL data_order: got %0h, expected %0h", dout, exp_d);
                    end
                end
            end
            if (wr_en) begin
                mem[wr_ptr] = din;
                exp_q.push_back(din);
            end
        end
        drive(0, 0, 0, 0);
        n_vec++;
        if (int'(count) != exp_q.size()) begin
            n_fail++;
            $display("FAIL occupancy: got count=%0d, expected %0d", count, exp_q.size());
        end
        exp_q.delete();

        // reset in the middle of traffic at count 3
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 1, 0, 0);
        check_outs("pre_reset", mk(1, 1, 0, 0, 1, 1, 1, 1, 3, 0, 3, 0, 0, 1, 0).exp);
        rst = 1'b1;
        drive(1, 1, 0, 0);
        rst = 1'b0;
        check_outs("mid_reset", mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0).exp);

        drive(0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
